// File: rtl/exec_wb_stage.sv
// Execute/writeback stage: ALU, operand-2 mux, load aligner, registered writeback, load-wait FSM.
// Latency: 1 cycle for ALU ops; 1 cycle after ahb_ready_in for loads; fault after LOAD_TIMEOUT wait cycles.
// Backpressure: ready_out drops while a load waits on the bus; EXEC_WB_MISALIGN_CHECK_EN adds misalign faults.
module exec_wb_stage #(
    parameter int XLEN         = 32,
    parameter int LOAD_TIMEOUT = 16
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            flush_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [3:0]      opcode_in,
    input  logic            alu_src_in,
    input  logic [2:0]      wb_mux_sel_in,
    input  logic [XLEN-1:0] op_1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [XLEN-1:0] iadder_out_in,
    input  logic [XLEN-1:0] csr_data_in,
    input  logic [XLEN-1:0] pc_plus_4_in,
    input  logic            is_load_in,
    input  logic [1:0]      load_size_in,
    input  logic            load_unsigned_in,
    input  logic [4:0]      rd_addr_in,
    input  logic            rf_wr_en_in,
    input  logic [XLEN-1:0] dmdata_in,
    input  logic            ahb_ready_in,
    input  logic            ahb_resp_in,
    output logic            wb_valid_out,
    output logic            wb_wr_en_out,
    output logic [4:0]      wb_rd_addr_out,
    output logic [XLEN-1:0] wb_data_out,
    output logic            load_fault_out
);
    localparam int SHW  = $clog2(XLEN);
    localparam int OFFW = $clog2(XLEN / 8);

    typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic              ld_uns_q, ld_uns_d;
    logic [OFFW-1:0]   ld_off_q, ld_off_d;
    logic [4:0]        ld_rd_q, ld_rd_d;
    logic              ld_wr_q, ld_wr_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_wr_en_q, wb_wr_en_d;
    logic [4:0]        wb_rd_addr_q, wb_rd_addr_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              load_fault_q, load_fault_d;

    logic [XLEN-1:0]   op2, alu_res, wb_sel_res;
    logic [SHW-1:0]    shamt;
    logic              misalign, take_op, take_ld, ld_mis, ld_done, ld_err;

    // Lane select masks offset bits below the access size, then extends from the access width.
    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] d, input logic [OFFW-1:0] off,
                                              input logic [1:0] sz, input logic uns);
        logic [OFFW-1:0] lane;
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] r;
        int              k;
        lane = off;
        case (sz)
            2'b00:   k = XLEN - 8;
            2'b01:   begin lane[0] = 1'b0; k = XLEN - 16; end
            2'b10:   begin lane[1:0] = 2'b00; k = (XLEN == 64) ? 32 : 0; end
            default: begin lane = '0; k = 0; end
        endcase
        sh = d >> {lane, 3'b000};
        r  = sh << k;
        return uns ? (r >> k) : XLEN'($signed(r) >>> k);
    endfunction

`ifdef EXEC_WB_MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (load_size_in)
            2'b01:   misalign = iadder_out_in[0];
            2'b10:   misalign = (iadder_out_in[1:0] != 2'b00);
            default: misalign = (load_size_in == 2'b11) && (iadder_out_in[OFFW-1:0] != '0);
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        op2     = alu_src_in ? imm_in : rs2_in;
        shamt   = op2[SHW-1:0];
        alu_res = '0;
        case (opcode_in)
            4'b0000: alu_res = op_1_in + op2;
            4'b1000: alu_res = op_1_in - op2;
            4'b0001: alu_res = op_1_in << shamt;
            4'b0010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_1_in) < $signed(op2))};
            4'b0011: alu_res = {{(XLEN-1){1'b0}}, (op_1_in < op2)};
            4'b0100: alu_res = op_1_in ^ op2;
            4'b0101: alu_res = op_1_in >> shamt;
            4'b1101: alu_res = $signed(op_1_in) >>> shamt;
            4'b0110: alu_res = op_1_in | op2;
            4'b0111: alu_res = op_1_in & op2;
            default: alu_res = '0;
        endcase
        case (wb_mux_sel_in)
            3'b001:  wb_sel_res = align(dmdata_in, iadder_out_in[OFFW-1:0], load_size_in, load_unsigned_in);
            3'b010:  wb_sel_res = imm_in;
            3'b011:  wb_sel_res = iadder_out_in;
            3'b100:  wb_sel_res = csr_data_in;
            3'b101:  wb_sel_res = pc_plus_4_in;
            default: wb_sel_res = alu_res;
        endcase
    end

    // Flush masks every event; a bus ready beats the timeout in the final count cycle.
    assign take_op = (state_q == IDLE) && valid_in && !flush_in && !is_load_in;
    assign take_ld = (state_q == IDLE) && valid_in && !flush_in && is_load_in && !misalign;
    assign ld_mis  = (state_q == IDLE) && valid_in && !flush_in && is_load_in && misalign;
    assign ld_done = (state_q == WAIT_LOAD) && !flush_in && ahb_ready_in && !ahb_resp_in;
    assign ld_err  = (state_q == WAIT_LOAD) && !flush_in &&
                     ((ahb_ready_in && ahb_resp_in) ||
                      (!ahb_ready_in && (cnt_q == 8'(LOAD_TIMEOUT - 1))));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ld_size_q    <= '0;
            ld_uns_q     <= 1'b0;
            ld_off_q     <= '0;
            ld_rd_q      <= '0;
            ld_wr_q      <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_wr_en_q   <= 1'b0;
            wb_rd_addr_q <= '0;
            wb_data_q    <= '0;
            load_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ld_size_q    <= ld_size_d;
            ld_uns_q     <= ld_uns_d;
            ld_off_q     <= ld_off_d;
            ld_rd_q      <= ld_rd_d;
            ld_wr_q      <= ld_wr_d;
            wb_valid_q   <= wb_valid_d;
            wb_wr_en_q   <= wb_wr_en_d;
            wb_rd_addr_q <= wb_rd_addr_d;
            wb_data_q    <= wb_data_d;
            load_fault_q <= load_fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_size_d = ld_size_q;
        ld_uns_d  = ld_uns_q;
        ld_off_d  = ld_off_q;
        ld_rd_d   = ld_rd_q;
        ld_wr_d   = ld_wr_q;
        if (flush_in) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (take_ld) begin
                    state_d   = WAIT_LOAD;
                    cnt_d     = '0;
                    ld_size_d = load_size_in;
                    ld_uns_d  = load_unsigned_in;
                    ld_off_d  = iadder_out_in[OFFW-1:0];
                    ld_rd_d   = rd_addr_in;
                    ld_wr_d   = rf_wr_en_in;
                end
                default: if (ld_done || ld_err) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            endcase
        end
    end

    always_comb begin
        wb_valid_d   = 1'b0;
        wb_wr_en_d   = 1'b0;
        load_fault_d = 1'b0;
        wb_rd_addr_d = wb_rd_addr_q;
        wb_data_d    = wb_data_q;
        if (take_op) begin
            wb_valid_d   = 1'b1;
            wb_wr_en_d   = rf_wr_en_in;
            wb_rd_addr_d = rd_addr_in;
            wb_data_d    = wb_sel_res;
        end else if (ld_mis) begin
            wb_valid_d   = 1'b1;
            load_fault_d = 1'b1;
            wb_rd_addr_d = rd_addr_in;
            wb_data_d    = '0;
        end else if (ld_done) begin
            wb_valid_d   = 1'b1;
            wb_wr_en_d   = ld_wr_q;
            wb_rd_addr_d = ld_rd_q;
            wb_data_d    = align(dmdata_in, ld_off_q, ld_size_q, ld_uns_q);
        end else if (ld_err) begin
            wb_valid_d   = 1'b1;
            load_fault_d = 1'b1;
            wb_rd_addr_d = ld_rd_q;
            wb_data_d    = '0;
        end
    end

    assign ready_out      = (state_q == IDLE);
    assign wb_valid_out   = wb_valid_q;
    assign wb_wr_en_out   = wb_wr_en_q;
    assign wb_rd_addr_out = wb_rd_addr_q;
    assign wb_data_out    = wb_data_q;
    assign load_fault_out = load_fault_q;
endmodule

// File: doc/exec_wb_stage.md
Name: exec_wb_stage

Overview:
- Parametrised, registered successor to the combinational execute/writeback stage.
- Contains the ALU, the operand-2 mux, the load-data aligner and the writeback mux, with a registered writeback output.
- Adds a load-wait FSM that holds the stage until the data bus completes, plus bus-error and timeout faults and a pipeline flush.
- Sits between the decode/operand stage and the register-file write port.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- LOAD_TIMEOUT, 16, maximum cycles spent in WAIT_LOAD before a timeout fault; legal range 1..255.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_n_in  in  1  asynchronous active-low reset.
- flush_in  in  1  synchronous flush; discards the in-flight operation.
- valid_in  in  1  operation presented.
- ready_out  out  1  stage can accept; equals (state==IDLE).
- opcode_in  in  4  ALU op {funct7[5],funct3}.
- alu_src_in  in  1  1: operand 2 = imm_in; 0: operand 2 = rs2_in.
- wb_mux_sel_in  in  3  writeback source select.
- op_1_in, rs2_in, imm_in, iadder_out_in, csr_data_in, pc_plus_4_in  in  XLEN each  operands.
- is_load_in  in  1  operation is a load.
- load_size_in  in  2  00 byte, 01 half, 10 word, 11 double (XLEN=64 only).
- load_unsigned_in  in  1  zero-extend load data.
- rd_addr_in  in  5  destination register.
- rf_wr_en_in  in  1  writes the register file.
- dmdata_in  in  XLEN  bus read data.
- ahb_ready_in  in  1  bus transfer complete.
- ahb_resp_in  in  1  bus error; sampled with ahb_ready_in.
- wb_valid_out  out  1  one-cycle writeback strobe.
- wb_wr_en_out  out  1  register-file write enable (qualified).
- wb_rd_addr_out  out  5  writeback register.
- wb_data_out  out  XLEN  writeback data.
- load_fault_out  out  1  one-cycle pulse: load error or timeout.

Behaviour:
- Reset: state IDLE. wb_valid_out, wb_wr_en_out, wb_rd_addr_out, wb_data_out, load_fault_out and the timeout counter all go to 0. ready_out is 1.
- ALU opcodes:
  - 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT (signed), 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
  - All other opcodes give 0.
  - Shift amount is operand2[log2(XLEN)-1:0]. Add/sub wrap modulo 2^XLEN.
- Writeback select: 000 ALU, 001 load data, 010 imm, 011 iadder, 100 csr, 101 pc+4. 110 and 111 give the ALU result.
- Load aligner:
  - Byte lane offset = iadder_out_in[log2(XLEN/8)-1:0].
  - Byte and half loads select the addressed lane; half uses lane offset with bit 0 ignored. Word on XLEN=64 uses offset bit 2.
  - Result is sign- or zero-extended per load_unsigned_in.
- FSM, IDLE:
  - valid_in & !is_load_in: result registered next edge. wb_valid_out=1 for one cycle and wb_wr_en_out=rf_wr_en_in. Latency 1.
  - valid_in & is_load_in: capture size, signedness, offset, rd and wr_en; go to WAIT_LOAD; counter=0.
- FSM, WAIT_LOAD (ready_out=0, inputs other than the bus ignored):
  - ahb_ready_in & !ahb_resp_in: register aligned data, pulse wb_valid_out, return to IDLE. Latency is 1 cycle after ready.
  - ahb_ready_in & ahb_resp_in: pulse wb_valid_out=1 and load_fault_out=1 with wb_wr_en_out=0 and wb_data_out=0, then return to IDLE.
  - No ahb_ready_in: counter increments. When the counter reaches LOAD_TIMEOUT-1 without ready, a fault completes exactly as for a bus error.
  - A ready arriving in the same cycle as the final count wins over the timeout.
- Flush:
  - flush_in in any state: state→IDLE, counter→0. No wb_valid_out is produced for the flushed operation or for a valid_in in the same cycle.
  - Flush wins over simultaneous ahb_ready_in.
- Outputs:
  - wb_* and load_fault_out are registered.
  - wb_valid_out and load_fault_out are strictly one-cycle pulses.
  - wb_data_out and wb_rd_addr_out hold their last value between pulses.
- Reset asserted mid-WAIT_LOAD: immediate return to the reset state with no output pulse.

Optional Feature:
- Macro: EXEC_WB_MISALIGN_CHECK_EN.
- Defined: a load is faulted in IDLE with no WAIT_LOAD entry when its address is misaligned for its size:
  - half with offset bit0=1,
  - word with offset bits[1:0]≠0,
  - double with offset≠0.
  - The fault completes on the next edge: wb_valid_out=1, load_fault_out=1, wb_wr_en_out=0.
- Undefined: low offset bits below the access size are ignored and no misalign fault exists.

Test Plan:
- ALU/mux: op_1=0xFFFFFFF0, rs2=0x10, opcode 0000, sel 000, rf_wr_en=1, rd=5 → next cycle wb_valid=1, wb_data=0x00000000, rd=5, wr_en=1.
- SRA/SLT: op_1=0x80000000, imm=4, alu_src=1, opcode 1101 → 0xF8000000; opcode 0010 with rs2=1 → 0x00000001.
- Load signed byte: offset 2, dmdata=0x12F45678, size 00, unsigned=0, ready after 3 wait cycles → ready_out=0 throughout the wait; wb_data=0xFFFFFFF4 one cycle after ready.
- Bus error: load, then ahb_ready=1 with resp=1 → wb_valid=1, load_fault=1, wr_en=0, wb_data=0; ready_out=1 on the following cycle.
- Timeout and flush:
  - LOAD_TIMEOUT=4 with ready never asserted → fault pulse 4 cycles after acceptance.
  - Separately, flush_in in the same cycle as ahb_ready=1 → no wb_valid and state IDLE.
- With EXEC_WB_MISALIGN_CHECK_EN: half load at offset 1 → fault next cycle with no wait. Without the macro, the same load with dmdata=0xABCD1234 and unsigned=1 gives 0x00001234.
